// File: rtl/cfg_bitstream_loader.sv
// Byte-wide bitstream loader: serializes MSB-first into CLB, CB and SB chains, then checks an XOR checksum.
// Latency: 9 cycles per full byte (accept + 8 shifts); result flags update on the edge after the checksum byte.
// Backpressure: s_ready is high only when the shift register is empty (or in CHK); s_valid low simply stalls.
module cfg_bitstream_loader #(
    parameter int CLB_BITS = 256,
    parameter int CB_BITS  = 160,
    parameter int SB_BITS  = 512
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] s_data,
    input  logic       s_valid,
    output logic       s_ready,
    output logic       prgm_b,
    output logic       CLB_prgm_b,
    output logic       cb_prgm_b,
    output logic       sb_prgm_b,
    output logic       CLB_prgm_b_in,
    output logic       cb_prgm_b_in,
    output logic       sb_prgm_b_in,
    output logic       bit_in_CLB,
    output logic       bit_in_CB,
    output logic       bit_in_SB,
    output logic       done,
    output logic       err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLB,
        S_CB,
        S_SB,
        S_CHK,
        S_DONE,
        S_ERR
    } state_t;

    localparam int MAX_AB   = (CLB_BITS > CB_BITS) ? CLB_BITS : CB_BITS;
    localparam int MAX_BITS = (MAX_AB > SB_BITS) ? MAX_AB : SB_BITS;
    localparam int CW       = $clog2(MAX_BITS + 1);

    localparam logic [CW-1:0] CLB_LAST = CW'(CLB_BITS - 1);
    localparam logic [CW-1:0] CB_LAST  = CW'(CB_BITS - 1);
    localparam logic [CW-1:0] SB_LAST  = CW'(SB_BITS - 1);

    state_t        state;
    logic [7:0]    shreg;
    logic [3:0]    bits_left;
    logic [CW-1:0] chain_cnt;
    logic [7:0]    acc;

    logic          in_chain;
    logic          shifting;
    logic          accept;
    logic [CW-1:0] chain_last;
    state_t        next_chain;

    assign in_chain = (state == S_CLB) || (state == S_CB) || (state == S_SB);
    assign shifting = in_chain && (bits_left != 4'd0);
    assign s_ready  = (in_chain && (bits_left == 4'd0)) || (state == S_CHK);
    assign accept   = s_valid && s_ready;

    always_comb begin
        chain_last = CLB_LAST;
        next_chain = S_CB;
        case (state)
            S_CB: begin
                chain_last = CB_LAST;
                next_chain = S_SB;
            end
            S_SB: begin
                chain_last = SB_LAST;
                next_chain = S_CHK;
            end
            default: begin
                chain_last = CLB_LAST;
                next_chain = S_CB;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            shreg     <= 8'd0;
            bits_left <= 4'd0;
            chain_cnt <= '0;
            acc       <= 8'd0;
            prgm_b    <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start) begin
                        state     <= S_CLB;
                        bits_left <= 4'd0;
                        chain_cnt <= '0;
                        acc       <= 8'd0;
                        prgm_b    <= 1'b0;
                        done      <= 1'b0;
                        err       <= 1'b0;
                    end
                end
                S_CLB, S_CB, S_SB: begin
                    if (shifting) begin
                        shreg <= {shreg[6:0], 1'b0};
                        // Chain full: drop the rest of the byte so the next chain starts byte-aligned.
                        if (chain_cnt == chain_last) begin
                            chain_cnt <= '0;
                            bits_left <= 4'd0;
                            state     <= next_chain;
                        end else begin
                            chain_cnt <= chain_cnt + 1'b1;
                            bits_left <= bits_left - 4'd1;
                        end
                    end else if (accept) begin
                        shreg     <= s_data;
                        bits_left <= 4'd8;
                        acc       <= acc ^ s_data;
                    end
                end
                S_CHK: begin
                    if (accept) begin
                        if (s_data == acc) begin
                            state  <= S_DONE;
                            prgm_b <= 1'b1;
                            done   <= 1'b1;
                        end else begin
                            state <= S_ERR;
                            err   <= 1'b1;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Strobes are decoded from flops only, so reset clears them immediately.
    always_comb begin
        CLB_prgm_b    = 1'b0;
        cb_prgm_b     = 1'b0;
        sb_prgm_b     = 1'b0;
        CLB_prgm_b_in = 1'b0;
        cb_prgm_b_in  = 1'b0;
        sb_prgm_b_in  = 1'b0;
        bit_in_CLB    = 1'b0;
        bit_in_CB     = 1'b0;
        bit_in_SB     = 1'b0;
        if (shifting) begin
            case (state)
                S_CLB: begin
                    CLB_prgm_b    = 1'b1;
                    CLB_prgm_b_in = (chain_cnt == '0);
                    bit_in_CLB    = shreg[7];
                end
                S_CB: begin
                    cb_prgm_b    = 1'b1;
                    cb_prgm_b_in = (chain_cnt == '0);
                    bit_in_CB    = shreg[7];
                end
                S_SB: begin
                    sb_prgm_b    = 1'b1;
                    sb_prgm_b_in = (chain_cnt == '0);
                    bit_in_SB    = shreg[7];
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cfg_bitstream_loader.sv
// Bench for cfg_bitstream_loader: directed loads checked against a chain-bit model built from the byte list.
module tb_cfg_bitstream_loader;

    localparam int CLB_N = 12;
    localparam int CB_N  = 8;
    localparam int SB_N  = 20;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [7:0] s_data = 8'd0;
    logic       s_valid = 1'b0;
    logic       s_ready, prgm_b, done, err;
    logic       CLB_prgm_b, cb_prgm_b, sb_prgm_b;
    logic       CLB_prgm_b_in, cb_prgm_b_in, sb_prgm_b_in;
    logic       bit_in_CLB, bit_in_CB, bit_in_SB;

    cfg_bitstream_loader #(.CLB_BITS(CLB_N), .CB_BITS(CB_N), .SB_BITS(SB_N)) dut (
        .clk(clk), .reset(reset), .start(start), .s_data(s_data), .s_valid(s_valid),
        .s_ready(s_ready), .prgm_b(prgm_b),
        .CLB_prgm_b(CLB_prgm_b), .cb_prgm_b(cb_prgm_b), .sb_prgm_b(sb_prgm_b),
        .CLB_prgm_b_in(CLB_prgm_b_in), .cb_prgm_b_in(cb_prgm_b_in), .sb_prgm_b_in(sb_prgm_b_in),
        .bit_in_CLB(bit_in_CLB), .bit_in_CB(bit_in_CB), .bit_in_SB(bit_in_SB),
        .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    logic [7:0] stream [6] = '{8'hA5, 8'h3C, 8'hFF, 8'h01, 8'h02, 8'h03};
    logic exp_clb [CLB_N];
    logic exp_cb  [CB_N];
    logic exp_sb  [SB_N];
    logic [7:0] good_ck;

    int clb_idx = 0, cb_idx = 0, sb_idx = 0;
    int last_chain = -1;
    int last_cyc = 0;
    int cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Model: each chain takes ceil(bits/8) bytes in order, MSB first, truncated to its length.
    function automatic logic model_bit(input int base, input int i);
        logic [7:0] b;
        b = stream[base + i / 8];
        return b[7 - (i % 8)];
    endfunction

    task automatic mon_shift(input int ch, input logic bitv, input logic inj,
                             input string nm, inout int idx, input int len);
        if (idx >= len) begin
            chk({nm, "_extra_shift"}, 32'(idx), 32'(len - 1));
        end else begin
            if (ch == 0) chk({nm, "_bit"}, bitv, exp_clb[idx]);
            else if (ch == 1) chk({nm, "_bit"}, bitv, exp_cb[idx]);
            else chk({nm, "_bit"}, bitv, exp_sb[idx]);
            chk({nm, "_inject"}, inj, 32'(idx == 0));
        end
        if (last_chain >= 0 && last_chain != ch)
            chk("chain_gap_ok", 32'(cyc - last_cyc >= 2), 1);
        last_chain = ch;
        last_cyc = cyc;
        idx++;
    endtask

    // Compare process: every active cycle, strobes and serial data must match the model.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (!reset) begin
                chk("strobe_exclusive", 32'(int'(CLB_prgm_b) + int'(cb_prgm_b) + int'(sb_prgm_b) <= 1), 1);
                if (CLB_prgm_b) begin
                    chk("clb_others_quiet", {bit_in_CB, bit_in_SB, cb_prgm_b_in, sb_prgm_b_in}, 0);
                    mon_shift(0, bit_in_CLB, CLB_prgm_b_in, "clb", clb_idx, CLB_N);
                end else if (cb_prgm_b) begin
                    chk("cb_others_quiet", {bit_in_CLB, bit_in_SB, CLB_prgm_b_in, sb_prgm_b_in}, 0);
                    mon_shift(1, bit_in_CB, cb_prgm_b_in, "cb", cb_idx, CB_N);
                end else if (sb_prgm_b) begin
                    chk("sb_others_quiet", {bit_in_CLB, bit_in_CB, CLB_prgm_b_in, cb_prgm_b_in}, 0);
                    mon_shift(2, bit_in_SB, sb_prgm_b_in, "sb", sb_idx, SB_N);
                end else begin
                    chk("idle_quiet", {bit_in_CLB, bit_in_CB, bit_in_SB,
                                       CLB_prgm_b_in, cb_prgm_b_in, sb_prgm_b_in}, 0);
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input bit rnd);
        int budget;
        bit taken;
        budget = 200;
        taken = 0;
        s_data = b;
        while (!taken && budget > 0) begin
            s_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            taken = s_valid && s_ready;
            @(posedge clk);
            #1;
            budget--;
        end
        s_valid = 1'b0;
        if (!taken) chk("byte_accept_timeout", 0, 1);
    endtask

    task automatic pulse_start();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic clear_model();
        clb_idx = 0;
        cb_idx = 0;
        sb_idx = 0;
        last_chain = -1;
    endtask

    task automatic run_load(input logic [7:0] ck, input bit rnd, input bit good, input bit busy_start);
        int budget;
        clear_model();
        pulse_start();
        chk("start_clears_flags", {prgm_b, done, err}, 0);
        for (int i = 0; i < 6; i++) begin
            send_byte(stream[i], rnd);
            if (busy_start && i == 2) pulse_start();
        end
        send_byte(ck, rnd);
        budget = 50;
        while (budget > 0 && !(done || err)) begin
            @(negedge clk);
            budget--;
        end
        chk("result_done", done, 32'(good));
        chk("result_err", err, 32'(!good));
        chk("result_prgm_b", prgm_b, 32'(good));
        chk("result_s_ready", s_ready, 0);
        chk("clb_count", 32'(clb_idx), CLB_N);
        chk("cb_count", 32'(cb_idx), CB_N);
        chk("sb_count", 32'(sb_idx), SB_N);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [CLB_N-1:0] clb_v;
        logic [CB_N-1:0]  cb_v;
        logic [SB_N-1:0]  sb_v;
        int budget;

        for (int i = 0; i < CLB_N; i++) exp_clb[i] = model_bit(0, i);
        for (int i = 0; i < CB_N; i++)  exp_cb[i]  = model_bit((CLB_N + 7) / 8, i);
        for (int i = 0; i < SB_N; i++)  exp_sb[i]  = model_bit((CLB_N + 7) / 8 + (CB_N + 7) / 8, i);
        good_ck = 8'h00;
        for (int i = 0; i < 6; i++) good_ck = good_ck ^ stream[i];
        for (int i = 0; i < CLB_N; i++) clb_v[CLB_N-1-i] = exp_clb[i];
        for (int i = 0; i < CB_N; i++)  cb_v[CB_N-1-i]   = exp_cb[i];
        for (int i = 0; i < SB_N; i++)  sb_v[SB_N-1-i]   = exp_sb[i];
        chk("model_clb_bits", 32'(clb_v), 32'hA53);
        chk("model_cb_bits", 32'(cb_v), 32'hFF);
        chk("model_sb_bits", 32'(sb_v), 32'h01020);
        chk("model_checksum", 32'(good_ck), 32'h66);

        #1;
        chk("reset_outputs", {s_ready, prgm_b, CLB_prgm_b, cb_prgm_b, sb_prgm_b,
                              CLB_prgm_b_in, cb_prgm_b_in, sb_prgm_b_in,
                              bit_in_CLB, bit_in_CB, bit_in_SB, done, err}, 0);
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("idle_s_ready", s_ready, 0);
        chk("idle_prgm_b", prgm_b, 0);

        run_load(good_ck, 0, 1, 0);

        run_load(8'h67, 0, 0, 0);
        s_data = 8'h55;
        s_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("err_no_consume", s_ready, 0);
        end
        s_valid = 1'b0;
        chk("err_hold", {done, err, prgm_b}, 3'b010);

        run_load(good_ck, 1, 1, 0);

        clear_model();
        pulse_start();
        for (int i = 0; i < 4; i++) send_byte(stream[i], 0);
        budget = 40;
        while (budget > 0 && sb_idx < 5) begin
            @(negedge clk);
            #1;
            budget--;
        end
        chk("sb_five_shifts", 32'(sb_idx), 5);
        reset = 1'b1;
        #1;
        chk("midload_reset_outputs", {s_ready, prgm_b, CLB_prgm_b, cb_prgm_b, sb_prgm_b,
                                      CLB_prgm_b_in, cb_prgm_b_in, sb_prgm_b_in,
                                      bit_in_CLB, bit_in_CB, bit_in_SB, done, err}, 0);
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("post_reset_idle", {s_ready, CLB_prgm_b, cb_prgm_b, sb_prgm_b}, 0);
        end
        @(posedge clk);
        #1;
        run_load(good_ck, 0, 1, 0);

        run_load(good_ck, 0, 1, 1);

        chk("before_reload_prgm_b", prgm_b, 1);
        run_load(good_ck, 0, 1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
